// File: rtl/irom_fetch_pkg.sv
// Shared types and sizing for the IROM read-side fetcher.
// Keeps the FSM encoding and FIFO geometry in one place for the top and its FIFO.
package irom_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W = FIFO_PTR_W + 1;
  localparam int ROM_LAT    = 2;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CHK_W  = 16;

endpackage

// File: rtl/irom_fetch_fifo.sv
// Four-entry skid FIFO carrying {addr, data} beats from the ROM capture stage
// to the pixel stream; count feeds the fetcher's issue throttle.
module fetch_fifo
  import irom_fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  push,
  input  logic [ADDR_W-1:0]     push_addr,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  output logic [ADDR_W-1:0]     head_addr,
  output logic [DATA_W-1:0]     head_data,
  output logic [FIFO_CNT_W-1:0] count,
  output logic                  empty
);

  logic [ADDR_W-1:0]     addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0]     data_mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr;
  logic [FIFO_PTR_W-1:0] rd_ptr;

  // Storage is cleared on reset so an empty FIFO presents a zero head beat.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        addr_mem[wr_ptr] <= push_addr;
        data_mem[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + FIFO_PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + FIFO_CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - FIFO_CNT_W'(1);
      end
    end
  end

  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];
  assign empty     = (count == '0);

endmodule

// File: rtl/irom_fetch.sv
// Read-side master for the 64x8 IROM: issues every address, absorbs the two-edge
// ROM latency, streams {addr, pixel} beats over valid/ready and sums the image.
module irom_fetch
  import irom_fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CHK_W  = DEF_CHK_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              IROM_CEN,
  output logic [ADDR_W-1:0] IROM_A,
  input  logic [DATA_W-1:0] IROM_Q,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [DATA_W-1:0] pix_data,
  output logic [CHK_W-1:0]  checksum
);

  localparam int                PEND_W    = $clog2(FIFO_DEPTH + ROM_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_W-1:0]     next_addr;
  logic [ADDR_W-1:0]     next_addr_nxt;
  logic [ADDR_W-1:0]     issue_addr;
  logic [ADDR_W-1:0]     rom_addr;
  logic                  issue;
  logic                  pop;
  logic                  rom_valid;
  logic                  fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [PEND_W-1:0]     pending;

  assign pix_valid = !fifo_empty;
  assign pop       = pix_valid && pix_ready;
  assign busy      = (state == FETCH) || (state == DRAIN);
  assign done      = (state == DONE);

  // Slots committed once this edge settles: FIFO after push/pop plus the request the ROM is sampling now.
  assign pending = PEND_W'(fifo_count) + PEND_W'(rom_valid) + PEND_W'(!IROM_CEN) - PEND_W'(pop);

  always_comb begin
    state_nxt     = state;
    next_addr_nxt = next_addr;
    issue         = 1'b0;
    issue_addr    = next_addr;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = FETCH;
          issue         = 1'b1;
          issue_addr    = '0;
          next_addr_nxt = ADDR_W'(1);
        end
      end
      FETCH: begin
        if (pending < PEND_W'(FIFO_DEPTH)) begin
          issue = 1'b1;
          if (next_addr == LAST_ADDR) begin
            state_nxt = DRAIN;
          end else begin
            next_addr_nxt = next_addr + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        if (pop && (pix_addr == LAST_ADDR)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // rom_valid/rom_addr track the request the ROM sampled last edge; its Q is captured now.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      next_addr <= '0;
      IROM_CEN  <= 1'b1;
      IROM_A    <= '0;
      rom_valid <= 1'b0;
      rom_addr  <= '0;
      checksum  <= '0;
    end else begin
      state     <= state_nxt;
      next_addr <= next_addr_nxt;
      IROM_CEN  <= !issue;
      if (issue) begin
        IROM_A <= issue_addr;
      end
      rom_valid <= !IROM_CEN;
      rom_addr  <= IROM_A;
      if ((state == IDLE) && start) begin
        checksum <= '0;
      end else if (pop) begin
        checksum <= checksum + CHK_W'(pix_data);
      end
    end
  end

  fetch_fifo #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_fifo (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .push     (rom_valid),
    .push_addr(rom_addr),
    .push_data(IROM_Q),
    .pop      (pop),
    .head_addr(pix_addr),
    .head_data(pix_data),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_irom_fetch.sv
// Bench for irom_fetch: a behavioural ROM plus a table of image runs, each checked
// against the expected beat order (addr i carries rom[i]) and the modular image sum.
module tb_irom_fetch;
  import irom_fetch_pkg::*;

  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int CW    = 16;
  localparam int DEPTH = 1 << AW;

  logic          CLK;
  logic          RST_N;
  logic          start;
  logic          busy;
  logic          done;
  logic          IROM_CEN;
  logic [AW-1:0] IROM_A;
  logic [DW-1:0] IROM_Q;
  logic          pix_valid;
  logic          pix_ready;
  logic [AW-1:0] pix_addr;
  logic [DW-1:0] pix_data;
  logic [CW-1:0] checksum;

  logic [DW-1:0] rom_mem [DEPTH];
  int checks   = 0;
  int failures = 0;

  // pattern: 0 identity, 1 all 0xFF, 2 random; mode: 0 ready, 1 toggle, 2 random, 3 stall at beat 5
  typedef struct {
    int          pattern;
    int          mode;
    bit          noise;
    int          abort_beat;
    bit          chk_known;
    logic [15:0] exp_chk;
    int          exp_done_k;
  } vec_t;

  vec_t vecs [8];

  irom_fetch #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .CHK_W (CW)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .IROM_CEN (IROM_CEN),
    .IROM_A   (IROM_A),
    .IROM_Q   (IROM_Q),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_addr (pix_addr),
    .pix_data (pix_data),
    .checksum (checksum)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (!IROM_CEN) IROM_Q <= rom_mem[IROM_A];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_cen"},      32'(IROM_CEN),  32'd1);
    checkOutput({tag, "_a"},        32'(IROM_A),    32'd0);
    checkOutput({tag, "_busy"},     32'(busy),      32'd0);
    checkOutput({tag, "_done"},     32'(done),      32'd0);
    checkOutput({tag, "_valid"},    32'(pix_valid), 32'd0);
    checkOutput({tag, "_pix_addr"}, 32'(pix_addr),  32'd0);
    checkOutput({tag, "_pix_data"}, 32'(pix_data),  32'd0);
    checkOutput({tag, "_checksum"}, 32'(checksum),  32'd0);
  endtask

  task automatic applyStimulus(input vec_t v);
    int            issued;
    int            popped;
    int            done_k;
    int            stall_left;
    int            sum;
    bit            seen_valid;
    bit            finished;
    bit            stall_checked;
    logic          rdy;
    logic [CW-1:0] exp_chk;

    sum = 0;
    for (int i = 0; i < DEPTH; i++) begin
      case (v.pattern)
        0:       rom_mem[AW'(i)] = DW'(i);
        1:       rom_mem[AW'(i)] = '1;
        default: rom_mem[AW'(i)] = DW'($urandom);
      endcase
      sum += int'(rom_mem[AW'(i)]);
    end
    exp_chk = v.chk_known ? v.exp_chk : CW'(sum);

    issued        = 0;
    popped        = 0;
    done_k        = -1;
    stall_left    = 10;
    seen_valid    = 1'b0;
    finished      = 1'b0;
    stall_checked = 1'b0;

    @(negedge CLK);
    start     = 1'b1;
    pix_ready = 1'b1;
    @(posedge CLK);

    for (int k = 0; k < 1000 && !finished; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        start = 1'b0;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        checkOutput("chk_cleared", 32'(checksum), 32'd0);
      end
      if (v.noise && k == 10) start = 1'b1;
      if (v.noise && k == 11) start = 1'b0;

      if (done_k >= 0) begin
        start = 1'b0;
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        checkOutput("busy_idle", 32'(busy), 32'd0);
        checkOutput("cen_idle", 32'(IROM_CEN), 32'd1);
        checkOutput("chk_hold", 32'(checksum), 32'(exp_chk));
        finished = 1'b1;
      end else if (done) begin
        done_k = k;
        checkOutput("beats_at_done", 32'(popped), 32'(DEPTH));
        checkOutput("busy_at_done", 32'(busy), 32'd0);
        checkOutput("cen_at_done", 32'(IROM_CEN), 32'd1);
        checkOutput("checksum", 32'(checksum), 32'(exp_chk));
        if (v.exp_done_k >= 0) checkOutput("done_edge", 32'(k), 32'(v.exp_done_k));
        if (v.noise) start = 1'b1;
        pix_ready = 1'b1;
      end else begin
        if (!IROM_CEN) begin
          checkOutput("issue_addr", 32'(IROM_A), 32'(issued));
          issued++;
        end
        checkOutput("pending_le4", 32'((issued - popped) <= 4), 32'd1);
        if (pix_valid && !seen_valid) begin
          seen_valid = 1'b1;
          if (v.mode == 0) checkOutput("first_valid_edge", 32'(k), 32'd2);
        end

        case (v.mode)
          0: rdy = 1'b1;
          1: rdy = (k % 2 == 0);
          2: rdy = 1'($urandom_range(0, 1));
          default: begin
            if (popped == 5 && stall_left > 0) begin
              rdy = 1'b0;
              stall_left--;
            end else begin
              if (stall_left == 0 && !stall_checked) begin
                stall_checked = 1'b1;
                checkOutput("stall_pending_full", 32'(issued - popped), 32'd4);
                checkOutput("stall_cen_high", 32'(IROM_CEN), 32'd1);
                checkOutput("stall_a_hold", 32'(IROM_A), 32'(issued - 1));
              end
              rdy = 1'b1;
            end
          end
        endcase
        pix_ready = rdy;

        if (v.abort_beat >= 0 && popped == v.abort_beat) begin
          RST_N = 1'b0;
          #1;
          checkReset("abort");
          @(negedge CLK);
          @(negedge CLK);
          RST_N     = 1'b1;
          start     = 1'b0;
          pix_ready = 1'b1;
          return;
        end

        if (pix_valid && rdy) begin
          if (popped < DEPTH) begin
            checkOutput("beat_addr", 32'(pix_addr), 32'(popped));
            checkOutput("beat_data", 32'(pix_data), 32'(rom_mem[AW'(popped)]));
          end else begin
            checkOutput("extra_beat", 32'(popped), 32'(DEPTH - 1));
          end
          popped++;
        end
      end
    end
    checkOutput("run_finished", 32'(finished), 32'd1);
  endtask

  initial begin
    vec_t rv;
    RST_N     = 1'b0;
    start     = 1'b0;
    pix_ready = 1'b0;

    vecs[0] = '{0, 0, 1'b0, -1, 1'b1, 16'h07E0, 66};
    vecs[1] = '{0, 3, 1'b0, -1, 1'b1, 16'h07E0, -1};
    vecs[2] = '{0, 1, 1'b0, -1, 1'b1, 16'h07E0, -1};
    vecs[3] = '{0, 0, 1'b1, -1, 1'b1, 16'h07E0, 66};
    vecs[4] = '{0, 0, 1'b0, 30, 1'b0, 16'h0000, -1};
    vecs[5] = '{0, 0, 1'b0, -1, 1'b1, 16'h07E0, 66};
    vecs[6] = '{1, 0, 1'b0, -1, 1'b1, 16'h3FC0, 66};
    vecs[7] = '{2, 2, 1'b0, -1, 1'b0, 16'h0000, -1};

    repeat (2) @(negedge CLK);
    checkReset("por");
    RST_N = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
    end

    for (int r = 0; r < 3; r++) begin
      rv = '{2, r % 3, 1'b0, -1, 1'b0, 16'h0000, (r % 3 == 0) ? 66 : -1};
      applyStimulus(rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
